icap_bitstream_loader: RTL and testbench

ICAP_BITSTREAM_LOADER -- requirements
Module: icap_bitstream_loader

---
 rtl/icap_bitstream_loader.sv | 155 +++++++++++++++
 tb/tb_icap_bitstream_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/icap_bitstream_loader.sv
// Streams 32-bit bitstream words from a valid/ready source into a configuration
// access port (ICAP), buffering through a small FIFO and framing the write sequence.
module icap_bitstream_loader #(
  parameter int FIFO_DEPTH = 16,
  parameter bit BIT_SWAP   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] word_count,
  input  logic        abort,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        icap_csb,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic        icap_busy,
  output logic        active,
  output logic        done,
  output logic        err,
  output logic [23:0] words_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  logic [2:0]    state;
  logic [23:0]   count_q;
  logic [23:0]   accepted;
  logic          aborted;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          abort_hit;
  logic          push;
  logic          pop;
  logic          flush;
  logic [31:0]   issue_word;

  // Byte 0 sits in [31:24]; ICAP expects each byte with its bits mirrored.
  function automatic logic [31:0] bit_swap(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++)
        r[8*b+k] = w[8*b+7-k];
    return r;
  endfunction

  assign abort_hit  = abort && (state == SETUP || state == STREAM);
  assign s_ready    = (state == STREAM) && (occ != DEPTH) && (accepted < count_q);
  assign push       = s_valid && s_ready && !abort_hit;
  // Pop looks only at registered occupancy, so an empty FIFO never bypasses a push.
  assign pop        = (state == STREAM) && !abort_hit && (occ != '0) && !icap_busy;
  assign flush      = abort_hit || (state == IDLE && start);
  assign issue_word = BIT_SWAP ? bit_swap(mem[rd_ptr]) : mem[rd_ptr];

  assign active = (state != IDLE);
  assign done   = (state == FINISH) && !aborted;

  // NOTE: buffer storage is deliberately not reset; occupancy and pointers alone
  // define which entries are meaningful, and resetting the array costs a flop mux per bit.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // NOTE: every sequential assignment is non-blocking so all flops sample the
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count_q    <= '0;
      accepted   <= '0;
      words_sent <= '0;
      aborted    <= 1'b0;
      icap_csb   <= 1'b1;
      icap_rdwrb <= 1'b1;
      icap_i     <= '0;
      err        <= 1'b0;
    end else begin
      err      <= 1'b0;
      icap_csb <= 1'b1;
      if (push) accepted <= accepted + 24'd1;
      case (state)
        IDLE: begin
          if (start) begin
            if (word_count == 24'd0) begin
              err <= 1'b1;
            end else begin
              state      <= SETUP;
              count_q    <= word_count;
              accepted   <= '0;
              words_sent <= '0;
              aborted    <= 1'b0;
              icap_rdwrb <= 1'b0;
            end
          end
        end
        SETUP: begin
          state <= abort ? HOLD : STREAM;
          if (abort) begin
            err     <= 1'b1;
            aborted <= 1'b1;
          end
        end
        STREAM: begin
          if (abort) begin
            state   <= HOLD;
            err     <= 1'b1;
            aborted <= 1'b1;
          end else if (words_sent == count_q) begin
            // Last word has already had its CSB-low cycle; close the frame.
            state <= HOLD;
          end
          if (pop) begin
            icap_i     <= issue_word;
            icap_csb   <= 1'b0;
            words_sent <= words_sent + 24'd1;
          end
        end
        HOLD: begin
          state      <= FINISH;
          icap_rdwrb <= 1'b1;
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icap_bitstream_loader.sv
// Directed plus randomized checks of the ICAP loader against a queue-based
// reference of which words must reach ICAP, in what order and with what framing.
module tb_icap_bitstream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] word_count;
  logic        abort;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        icap_csb;
  logic        icap_rdwrb;
  logic [31:0] icap_i;
  logic        icap_busy;
  logic        active;
  logic        done;
  logic        err;
  logic [23:0] words_sent;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] src[$];
  logic [31:0] got[$];

  localparam logic [63:0] RST_VEC = {2'b00, 6'b011000, 32'h0, 24'h0};

  always #5 clk = ~clk;

  icap_bitstream_loader #(.FIFO_DEPTH(16), .BIT_SWAP(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .icap_csb(icap_csb),
    .icap_rdwrb(icap_rdwrb), .icap_i(icap_i), .icap_busy(icap_busy), .active(active),
    .done(done), .err(err), .words_sent(words_sent)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Mirror every bit of the word, then put the bytes back in place.
  function automatic logic [31:0] model_swap(input logic [31:0] w);
    logic [31:0] r;
    r = {<<{w}};
    return {<<8{r}};
  endfunction

  function automatic logic [63:0] out_vec();
    return {2'b00, s_ready, icap_csb, icap_rdwrb, active, done, err, icap_i, words_sent};
  endfunction

  task automatic fill_src(input int n);
    src.delete();
    for (int i = 0; i < n + 4; i++) src.push_back($urandom);
  endtask

  task automatic run_load(input int cnt, input int valid_pct, input int busy_pct,
                          input int busy_first, input bit restart_mid,
                          output int max_run, output int acc_rel);
    int acc = 0, cyc = 0, run = 0, done_n = 0, err_n = 0, bad_seq = 0;
    bit prev_csb, prev_rdwrb, rw_bad = 1'b0, rdy_bad = 1'b0;
    got.delete();
    max_run = 0;
    acc_rel = -1;
    @(negedge clk);
    prev_csb = icap_csb;
    prev_rdwrb = icap_rdwrb;
    start = 1'b1; word_count = 24'(cnt); s_valid = 1'b0; icap_busy = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (active && cyc < 2000) begin
      if (!icap_csb) begin
        got.push_back(icap_i);
        run++;
        if (run > max_run) max_run = run;
        if (icap_rdwrb !== 1'b0) rw_bad = 1'b1;
      end else run = 0;
      if (icap_rdwrb !== prev_rdwrb && !(icap_csb && prev_csb)) rw_bad = 1'b1;
      prev_csb = icap_csb;
      prev_rdwrb = icap_rdwrb;
      if (done) done_n++;
      if (err) err_n++;
      if (cyc == busy_first) acc_rel = acc;
      icap_busy = (cyc < busy_first) ? 1'b1 : ($urandom_range(99) < busy_pct);
      s_valid = (acc < src.size()) && ($urandom_range(99) < valid_pct);
      s_data = (acc < src.size()) ? src[acc] : $urandom;
      if (s_ready && acc >= cnt) rdy_bad = 1'b1;
      if (s_valid && s_ready) acc++;
      start = restart_mid && (cyc == 6);
      if (start) word_count = 24'(cnt + 7);
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0; icap_busy = 1'b0; start = 1'b0;
    for (int i = 0; i < got.size() && i < cnt; i++)
      if (got[i] !== model_swap(src[i])) bad_seq++;
    check("load_timeout", 64'(cyc >= 2000), 64'd0);
    check("issued_count", 64'(got.size()), 64'(cnt));
    check("issued_order", 64'(bad_seq), 64'd0);
    check("accepted_count", 64'(acc), 64'(cnt));
    check("done_pulses", 64'(done_n), 64'd1);
    check("err_pulses", 64'(err_n), 64'd0);
    check("words_sent", 64'(words_sent), 64'(cnt));
    check("rdwrb_framing", 64'(rw_bad), 64'd0);
    check("ready_past_count", 64'(rdy_bad), 64'd0);
    check("ready_idle", 64'(s_ready), 64'd0);
  endtask

  initial begin
    int mr, ar, seen, cyc, cnt;
    logic misc;
    rst = 1'b0; start = 1'b0; word_count = '0; abort = 1'b0;
    s_data = '0; s_valid = 1'b0; icap_busy = 1'b0;
    #1 rst = 1'b1;
    #2 check("reset_outputs", out_vec(), RST_VEC);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Abort while idle must do nothing.
    abort = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_idle", {62'b0, err, active}, 64'd0);
    abort = 1'b0;

    // Reference two-word load with known swapped values.
    src = '{32'hAA995566, 32'h20000000, 32'h11111111, 32'h22222222};
    run_load(2, 100, 0, 0, 1'b0, mr, ar);
    check("ref_word0", 64'(got.size() > 0 ? got[0] : 32'hx), 64'h5599AA66);
    check("ref_word1", 64'(got.size() > 1 ? got[1] : 32'hx), 64'h04000000);

    // Streaming throughput: one word per cycle once primed.
    fill_src(40);
    run_load(40, 100, 0, 0, 1'b0, mr, ar);
    check("burst_run_40", 64'(mr), 64'd40);

    // Back-pressure from ICAP: FIFO fills to depth, then drains in order.
    fill_src(20);
    run_load(20, 100, 0, 30, 1'b0, mr, ar);
    check("busy_fill_16", 64'(ar), 64'd16);

    // Zero-length start.
    @(negedge clk);
    start = 1'b1; word_count = 24'd0;
    @(negedge clk);
    start = 1'b0;
    check("zero_len_err", {60'b0, err, active, icap_csb, icap_rdwrb}, 64'b1011);
    @(negedge clk);
    check("zero_len_after", {62'b0, err, active}, 64'd0);

    // Abort after five issued words of ten.
    @(negedge clk);
    start = 1'b1; word_count = 24'd10; s_valid = 1'b0; icap_busy = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    cyc = 0;
    while (cyc < 200) begin
      if (!icap_csb) seen++;
      if (seen == 5) break;
      s_valid = 1'b1;
      s_data = $urandom;
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_5", 64'(seen), 64'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; s_valid = 1'b0;
    check("abort_hold", {59'b0, err, icap_csb, active, done, icap_rdwrb}, 64'b11100);
    check("abort_words_sent", 64'(words_sent), 64'd5);
    @(negedge clk);
    check("abort_finish", {60'b0, icap_rdwrb, done, err, icap_csb}, 64'b1001);
    @(negedge clk);
    check("abort_idle_after", {39'b0, active, words_sent}, {39'b0, 1'b0, 24'd5});

    // Randomized loads, some with a stray start mid-load.
    for (int k = 0; k < 4; k++) begin
      cnt = $urandom_range(50, 1);
      fill_src(cnt);
      run_load(cnt, $urandom_range(100, 40), $urandom_range(50, 0), 0, k[0], mr, ar);
    end

    // Reset in the middle of a stream, then a clean load.
    fill_src(30);
    @(negedge clk);
    start = 1'b1; word_count = 24'd30; icap_busy = 1'b0;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1;
    repeat (12) begin
      s_data = $urandom;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1 check("reset_mid_async", out_vec(), RST_VEC);
    @(negedge clk);
    check("reset_mid_held", out_vec(), RST_VEC);
    rst = 1'b0; s_valid = 1'b0;
    misc = 1'b0;
    repeat (3) begin
      @(negedge clk);
      misc = misc | err | done | active;
    end
    check("reset_no_pulses", 64'(misc), 64'd0);
    fill_src(8);
    run_load(8, 80, 20, 0, 1'b0, mr, ar);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
